dmem_wait: RTL

- Parametrised data-memory block for the next-generation core; replaces the fixed, zero-latency data memory.
- Adds a request/ready handshake, configurable wait states, byte-lane write enables and an error response for bad addresses.
- Sits between the core's memory port (ALU-result address, write data, read data) and on-chip RAM.
- The core stalls while a request is outstanding.

---
 rtl/dmem_wait.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dmem_wait.sv
// dmem_wait: data memory with a request/ready handshake, a configurable
// number of wait states, byte-lane write enables and an error response
// for misaligned or out-of-range addresses.
//
// Handshake: req is looked at only while the block is idle (busy=0); the
// edge that sees req=1 accepts the request and captures we/be/a/wd.
// Inputs are ignored from then on until the transaction completes.
// Completion is a single-cycle ready pulse; rd and err are meaningful only
// in that cycle and are forced to 0 otherwise. busy covers the span from
// acceptance through the ready cycle. Transactions never overlap.
module dmem_wait #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     a,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [3:0]        CNT_INIT   = 4'(LATENCY - 1);

  // Configuration sanity: reject illegal parameter sets at elaboration.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_wait: LATENCY must be in 1..15");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
    $error("dmem_wait: DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("dmem_wait: DEPTH must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                accept;

  logic                we_q;
  logic [LANES-1:0]    be_q;
  logic [ADDR_W-1:0]   a_q;
  logic [DATA_W-1:0]   wd_q;

  logic [ADDR_W-1:0]   word_full;
  logic [IDX_W-1:0]    idx;
  logic                bad_addr;
  logic                commit;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Address decode on the captured request: word index plus error flag.
  // Any address bit above the index field counts as out of range because
  // the full shifted address is compared against DEPTH.
  always_comb begin
    word_full = a_q >> OFF;
    idx       = word_full[IDX_W-1:0];
    bad_addr  = ((a_q & ALIGN_MASK) != '0) || (word_full >= DEPTH_A);
  end

  // Next-state, wait counter and acceptance decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Response outputs are decoded from the registered state only.
  always_comb begin
    ready  = 1'b0;
    err    = 1'b0;
    rd     = '0;
    busy   = (state_q != S_IDLE);
    commit = 1'b0;
    if (state_q == S_RESP) begin
      ready  = 1'b1;
      err    = bad_addr;
      commit = reset && we_q && !bad_addr;
      if (!we_q && !bad_addr) begin
        rd = mem[idx];
      end
    end
  end

  // State register, counter and captured request; all cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= '0;
      a_q     <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q <= we;
        be_q <= be;
        a_q  <= a;
        wd_q <= wd;
      end
    end
  end

  // Storage: enabled byte lanes land on the edge that ends the response
  // cycle. Contents are deliberately not reset. A reset during the
  // transaction leaves RESP asynchronously, so a pending write is dropped.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_q[i]) begin
          mem[idx][8*i +: 8] <= wd_q[8*i +: 8];
        end
      end
    end
  end

endmodule
